// File: rtl/rtc_pkg.sv
// rtc_pkg: shared digit indices, 7-segment patterns ({g..a}, active-high) and BCD decoder
package rtc_pkg;
  localparam logic [2:0] DIG_SL = 3'd0;
  localparam logic [2:0] DIG_SM = 3'd1;
  localparam logic [2:0] DIG_ML = 3'd2;
  localparam logic [2:0] DIG_MM = 3'd3;
  localparam logic [2:0] DIG_HL = 3'd4;
  localparam logic [2:0] DIG_HM = 3'd5;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high segments {g..a}; non-BCD shows a dash
//   digit in 4  value to show
//   blank in 1  force all segments off
//   seg   out 7 active-high segment pattern
module seg7_decode
  import rtc_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb seg = blank ? SEG_BLANK : bcd_to_seg(digit);
endmodule

// File: rtl/rtc_display_scan.sv
// rtc_display_scan: snapshots rtc BCD time once per frame and scans it onto a 6-digit 7-seg display
//   clk, rst (sync, active-low)
//   sl,sm,ml,mm,hl,hm in 4  BCD time digits (hours 24h)
//   mode_12h, blank_lz in 1 12h display / leading hour zero blanking
//   seg out 7, dp out 1, an out 6  display pins (polarity set by ACTIVE_LOW)
//   pm out 1  snapshot hour >= 12;  frame out 1  pulse when snapshot taken
module rtc_display_scan
  import rtc_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int GHOST_CYC   = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sl,
  input  logic [3:0] sm,
  input  logic [3:0] ml,
  input  logic [3:0] mm,
  input  logic [3:0] hl,
  input  logic [3:0] hm,
  input  logic       mode_12h,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       pm,
  output logic       frame
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic INV = ACTIVE_LOW != 0;
  logic [CW-1:0]   div_cnt;
  logic [2:0]      idx;
  logic            live;
  logic [5:0][3:0] sh;
  logic            tick;
  logic [6:0]      h_bin, h_c;
  logic            h_ok, pm_n;
  logic [3:0]      h_t, h_u;
  logic [6:0]      seg_d, seg_a;
  logic [5:0]      an_a;
  logic            dp_a;
  assign tick = div_cnt == CW'(REFRESH_DIV - 1);
  // Hours are converted once at snapshot time; anything out of range passes through raw.
  always_comb begin
    h_bin = 7'(hm) * 7'd10 + 7'(hl);
    h_ok  = hm <= 4'd9 && hl <= 4'd9 && h_bin <= 7'd23;
    pm_n  = h_ok && h_bin >= 7'd12;
    h_c   = h_bin == 7'd0 ? 7'd12 : h_bin > 7'd12 ? h_bin - 7'd12 : h_bin;
    h_t   = (mode_12h && h_ok) ? 4'(h_c >= 7'd10) : hm;
    h_u   = (mode_12h && h_ok) ? 4'(h_c >= 7'd10 ? h_c - 7'd10 : h_c) : hl;
  end
  seg7_decode u_dec (
    .digit(sh[idx]),
    .blank(blank_lz && idx == DIG_HM && sh[DIG_HM] == 4'd0),
    .seg  (seg_d)
  );
  // Nothing is lit until the first snapshot after reset has been taken.
  always_comb begin
    seg_a = live ? seg_d : SEG_BLANK;
    an_a  = (live && div_cnt >= CW'(GHOST_CYC)) ? 6'(1) << idx : 6'd0;
    dp_a  = live && (idx == DIG_ML || idx == DIG_HL) && !sh[DIG_SL][0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= DIG_SL;
      live    <= 1'b0;
      sh      <= '0;
      pm      <= 1'b0;
      frame   <= 1'b0;
      seg     <= {7{INV}};
      an      <= {6{INV}};
      dp      <= INV;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      frame   <= 1'b0;
      if (tick) begin
        if (!live || idx == DIG_HM) begin
          sh    <= {h_t, h_u, mm, ml, sm, sl};
          pm    <= pm_n;
          frame <= 1'b1;
          live  <= 1'b1;
          idx   <= DIG_SL;
        end else begin
          idx <= idx + 3'd1;
        end
      end
      seg <= seg_a ^ {7{INV}};
      an  <= an_a ^ {6{INV}};
      dp  <= dp_a ^ INV;
    end
  end
endmodule
